operands_lane_serializer: RTL

Parametrised successor to the operand-delivery channel between operand collection and the functional units. It accepts one full-warp operand packet (NUM_THREADS lanes of rs1/rs2/rs3), holds it in a one-entry buffer, and replays it to a narrower execute unit as NUM_LANES-wide beats tagged with packet id and start/end-of-packet markers. It uses the same valid/ready handshake on both sides.

---
 rtl/operands_lane_serializer_pkg.sv | 33 +++
 rtl/operands_lane_serializer_if.sv | 42 ++++
 rtl/operands_lane_serializer_pid_select.sv | 54 +++++
 rtl/operands_lane_serializer.sv | 129 ++++++++++++
 4 files changed

// File: rtl/operands_lane_serializer_pkg.sv
// Shared types and helpers for the operand lane serializer.
// Supplies fallback defaults for the NUM_THREADS / XLEN macros.
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef XLEN
`define XLEN 32
`endif

package operands_lane_serializer_pkg;

  typedef struct packed {
    logic [7:0]  uuid;
    logic [1:0]  wis;
    logic [31:0] pc;
    logic [2:0]  ex_type;
    logic [3:0]  op_type;
    logic [2:0]  op_args;
    logic        wb;
    logic [4:0]  rd;
    logic [5:0]  infl_id;
  } ops_hdr_t;

  localparam int unsigned OPS_HDR_W = $bits(ops_hdr_t);

  typedef enum logic [0:0] {StIdle, StBusy} ser_state_e;

  // Width of the beat index; never narrower than one bit.
  function automatic int unsigned pid_width(input int unsigned num_packets);
    return (num_packets <= 2) ? 1 : $clog2(num_packets);
  endfunction

endpackage

// File: rtl/operands_lane_serializer_if.sv
// Packet-in / beat-out bundle of the operand lane serializer.
interface operands_lane_serializer_if
  import operands_lane_serializer_pkg::*;
#(
    parameter int unsigned NUM_THREADS = `NUM_THREADS,
    parameter int unsigned NUM_LANES   = 2,
    parameter int unsigned XLEN        = `XLEN,
    parameter int unsigned HDR_W       = OPS_HDR_W
);
  localparam int unsigned PID_W = pid_width(NUM_THREADS / NUM_LANES);

  logic                        in_valid;
  logic                        in_ready;
  logic [HDR_W-1:0]            in_hdr;
  logic [NUM_THREADS-1:0]      in_tmask;
  logic [NUM_THREADS*XLEN-1:0] in_rs1_data;
  logic [NUM_THREADS*XLEN-1:0] in_rs2_data;
  logic [NUM_THREADS*XLEN-1:0] in_rs3_data;

  logic                        out_valid;
  logic                        out_ready;
  logic [HDR_W-1:0]            out_hdr;
  logic [NUM_LANES-1:0]        out_tmask;
  logic [NUM_LANES*XLEN-1:0]   out_rs1_data;
  logic [NUM_LANES*XLEN-1:0]   out_rs2_data;
  logic [NUM_LANES*XLEN-1:0]   out_rs3_data;
  logic [PID_W-1:0]            out_pid;
  logic                        out_sop;
  logic                        out_eop;

  modport slave (
    input  in_valid, in_hdr, in_tmask, in_rs1_data, in_rs2_data, in_rs3_data, out_ready,
    output in_ready, out_valid, out_hdr, out_tmask, out_rs1_data, out_rs2_data, out_rs3_data,
           out_pid, out_sop, out_eop
  );

  modport master (
    output in_valid, in_hdr, in_tmask, in_rs1_data, in_rs2_data, in_rs3_data, out_ready,
    input  in_ready, out_valid, out_hdr, out_tmask, out_rs1_data, out_rs2_data, out_rs3_data,
           out_pid, out_sop, out_eop
  );
endinterface

// File: rtl/operands_lane_serializer_pid_select.sv
// Beat sequencing: first, next and last group for a thread mask.
// With OPERANDS_SER_SKIP_EN defined, all-zero groups are skipped.
module operands_ser_pid_select
  import operands_lane_serializer_pkg::*;
#(
    parameter int unsigned NUM_THREADS = `NUM_THREADS,
    parameter int unsigned NUM_LANES   = 2,
    localparam int unsigned NUM_PACKETS = NUM_THREADS / NUM_LANES,
    localparam int unsigned PID_W       = pid_width(NUM_PACKETS)
) (
    input  logic [NUM_THREADS-1:0] tmask_i,
    input  logic [PID_W-1:0]       pid_i,
    output logic [PID_W-1:0]       first_pid_o,
    output logic [PID_W-1:0]       next_pid_o,
    output logic                   is_last_o
);

`ifdef OPERANDS_SER_SKIP_EN
    logic [NUM_PACKETS-1:0] nz;

    always_comb begin
        nz = '0;
        for (int g = 0; g < int'(NUM_PACKETS); g++) begin
            nz[g] = |tmask_i[g*NUM_LANES +: NUM_LANES];
        end
    end

    // Scan downwards so the lowest qualifying group wins; an empty mask yields pid 0, last.
    always_comb begin
        first_pid_o = '0;
        next_pid_o  = pid_i;
        is_last_o   = 1'b1;
        for (int g = int'(NUM_PACKETS) - 1; g >= 0; g--) begin
            if (nz[g]) begin
                first_pid_o = PID_W'(g);
            end
            if (nz[g] && (g > int'(pid_i))) begin
                next_pid_o = PID_W'(g);
                is_last_o  = 1'b0;
            end
        end
    end
`else
    logic unused_tmask;
    assign unused_tmask = ^tmask_i;

    always_comb begin
        first_pid_o = '0;
        is_last_o   = (int'(pid_i) == int'(NUM_PACKETS) - 1);
        next_pid_o  = is_last_o ? pid_i : pid_i + 1'b1;
    end
`endif

endmodule

// File: rtl/operands_lane_serializer.sv
// One-entry warp operand buffer replayed as NUM_LANES-wide beats.
// Optional OPERANDS_SER_SKIP_EN drops beats whose tmask slice is empty.
module operands_lane_serializer
  import operands_lane_serializer_pkg::*;
#(
    parameter int unsigned NUM_THREADS = `NUM_THREADS,
    parameter int unsigned NUM_LANES   = 2,
    parameter int unsigned XLEN        = `XLEN,
    parameter int unsigned HDR_W       = OPS_HDR_W
) (
    input logic                        clk,
    input logic                        reset,
    operands_lane_serializer_if.slave  bus
);

    localparam int unsigned NUM_PACKETS = NUM_THREADS / NUM_LANES;
    localparam int unsigned PID_W       = pid_width(NUM_PACKETS);
    localparam int unsigned OP_W        = NUM_THREADS * XLEN;
    localparam int unsigned BEAT_W      = NUM_LANES * XLEN;

    ser_state_e             state_q, state_d;
    logic [PID_W-1:0]       pid_q, pid_d;
    logic [HDR_W-1:0]       hdr_q, hdr_d;
    logic [NUM_THREADS-1:0] tmask_q, tmask_d;
    logic [OP_W-1:0]        rs1_q, rs1_d;
    logic [OP_W-1:0]        rs2_q, rs2_d;
    logic [OP_W-1:0]        rs3_q, rs3_d;

    logic             busy;
    logic             in_fire;
    logic             out_fire;
    logic [PID_W-1:0] cur_first_pid;
    logic [PID_W-1:0] cur_next_pid;
    logic             cur_last;
    logic [PID_W-1:0] in_first_pid;
    logic [PID_W-1:0] in_next_pid;
    logic             in_last;

    operands_ser_pid_select #(
        .NUM_THREADS (NUM_THREADS),
        .NUM_LANES   (NUM_LANES)
    ) u_cur_sel (
        .tmask_i     (tmask_q),
        .pid_i       (pid_q),
        .first_pid_o (cur_first_pid),
        .next_pid_o  (cur_next_pid),
        .is_last_o   (cur_last)
    );

    // Only first_pid matters for an incoming packet.
    operands_ser_pid_select #(
        .NUM_THREADS (NUM_THREADS),
        .NUM_LANES   (NUM_LANES)
    ) u_in_sel (
        .tmask_i     (bus.in_tmask),
        .pid_i       ('0),
        .first_pid_o (in_first_pid),
        .next_pid_o  (in_next_pid),
        .is_last_o   (in_last)
    );

    logic unused_in_sel;
    assign unused_in_sel = ^{in_next_pid, in_last};

    assign busy     = (state_q == StBusy);
    assign out_fire = busy && bus.out_ready;
    assign in_fire  = bus.in_valid && bus.in_ready;

    assign bus.in_ready     = !busy || (out_fire && cur_last);
    assign bus.out_valid    = busy;
    assign bus.out_pid      = pid_q;
    assign bus.out_sop      = busy && (pid_q == cur_first_pid);
    assign bus.out_eop      = busy && cur_last;
    assign bus.out_hdr      = busy ? hdr_q : '0;
    assign bus.out_tmask    = busy ? tmask_q[int'(pid_q)*NUM_LANES +: NUM_LANES] : '0;
    assign bus.out_rs1_data = busy ? rs1_q[int'(pid_q)*BEAT_W +: BEAT_W] : '0;
    assign bus.out_rs2_data = busy ? rs2_q[int'(pid_q)*BEAT_W +: BEAT_W] : '0;
    assign bus.out_rs3_data = busy ? rs3_q[int'(pid_q)*BEAT_W +: BEAT_W] : '0;

    always_comb begin
        state_d = state_q;
        pid_d   = pid_q;
        hdr_d   = hdr_q;
        tmask_d = tmask_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rs3_d   = rs3_q;

        if (out_fire) begin
            if (cur_last) begin
                state_d = StIdle;
            end else begin
                pid_d = cur_next_pid;
            end
        end

        // A load on the final beat overrides the return to idle.
        if (in_fire) begin
            state_d = StBusy;
            pid_d   = in_first_pid;
            hdr_d   = bus.in_hdr;
            tmask_d = bus.in_tmask;
            rs1_d   = bus.in_rs1_data;
            rs2_d   = bus.in_rs2_data;
            rs3_d   = bus.in_rs3_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            pid_q   <= '0;
            hdr_q   <= '0;
            tmask_q <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rs3_q   <= '0;
        end else begin
            state_q <= state_d;
            pid_q   <= pid_d;
            hdr_q   <= hdr_d;
            tmask_q <= tmask_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rs3_q   <= rs3_d;
        end
    end

endmodule
